// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//
// Parametrised UART transmitter. A payload is taken over a valid/ready
// handshake and sent as one frame: a start bit, DATA_WIDTH data bits (LSB
// first), an optional parity bit, then one or two stop bits. The bit period,
// parity mode and stop-bit count come from runtime inputs. They are captured
// together with the payload, so changing them while a frame is in flight has
// no effect on that frame.
//
// Parameters
//   DATA_WIDTH      data bits per frame (legal range 5..9)
//   PRESCALE_WIDTH  width of the prescale input
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active-high
//   prescale       clock cycles per serial bit (0 is treated as 1)
//   tx_data        frame payload, sent LSB first
//   tx_valid       payload valid
//   tx_ready       block can accept a payload this cycle (combinational)
//   parity_enable  1: insert a parity bit after the data bits
//   parity_type    0: even, 1: odd
//   stop_bits      0: one stop bit, 1: two stop bits
//   TX_OUT         serial line, idle high, registered
//   busy           frame in progress, registered
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [DATA_WIDTH-1:0]     tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic                      stop_bits,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                    state, state_next;
    logic [PRESCALE_WIDTH-1:0] bit_cnt, bit_cnt_next;
    logic [IDX_W-1:0]          bit_idx, bit_idx_next;
    logic                      stop_cnt, stop_cnt_next;
    logic [DATA_WIDTH-1:0]     data_lat;
    logic [PRESCALE_WIDTH-1:0] prescale_lat;
    logic                      parity_en_lat;
    logic                      parity_bit_lat;
    logic                      stop_two_lat;
    logic [PRESCALE_WIDTH-1:0] prescale_eff;
    logic                      accept;
    logic                      bit_end;
    logic                      tx_next;

    // A zero prescale would make the reload value wrap, so it is promoted to 1.
    assign prescale_eff = (prescale == '0) ? PRESCALE_ONE : prescale;

    // Reset is part of tx_ready so a source never sees a handshake that the
    // register file (held in reset) cannot honour.
    assign tx_ready = (state == IDLE) && !rst;
    assign accept   = (state == IDLE) && tx_valid;
    assign bit_end  = (bit_cnt == '0);

    // Next-state logic. The counter is reloaded with prescale-1 whenever a new
    // bit begins and counts down otherwise; a bit ends on the cycle it reads 0.
    // TX_OUT is derived from the next state so that the registered line lines
    // up exactly with the state it belongs to.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;
        tx_next       = 1'b1;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_next    = START;
                    bit_cnt_next  = prescale_eff - PRESCALE_ONE;
                    bit_idx_next  = '0;
                    stop_cnt_next = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = prescale_lat - PRESCALE_ONE;
                    bit_idx_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt - PRESCALE_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_next = prescale_lat - PRESCALE_ONE;
                    if (bit_idx == LAST_IDX) begin
                        state_next    = parity_en_lat ? PARITY : STOP;
                        stop_cnt_next = 1'b0;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - PRESCALE_ONE;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    bit_cnt_next  = prescale_lat - PRESCALE_ONE;
                    stop_cnt_next = 1'b0;
                end else begin
                    bit_cnt_next = bit_cnt - PRESCALE_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // A second stop bit is just another bit period in STOP.
                    if (stop_two_lat && !stop_cnt) begin
                        stop_cnt_next = 1'b1;
                        bit_cnt_next  = prescale_lat - PRESCALE_ONE;
                    end else begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - PRESCALE_ONE;
                end
            end
            default: begin
                state_next    = IDLE;
                bit_cnt_next  = '0;
                bit_idx_next  = '0;
                stop_cnt_next = 1'b0;
            end
        endcase

        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_lat[bit_idx_next];
            PARITY:  tx_next = parity_bit_lat;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    // State, counters and registered outputs. Reset forces the line high at
    // once, which aborts any frame in flight without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            bit_idx  <= bit_idx_next;
            stop_cnt <= stop_cnt_next;
            TX_OUT   <= tx_next;
            busy     <= (state_next != IDLE);
        end
    end

    // Frame shadow registers, captured only on accept. The parity bit is
    // precomputed here so the live parity inputs are never consulted again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_lat       <= '0;
            prescale_lat   <= '0;
            parity_en_lat  <= 1'b0;
            parity_bit_lat <= 1'b0;
            stop_two_lat   <= 1'b0;
        end else if (accept) begin
            data_lat       <= tx_data;
            prescale_lat   <= prescale_eff;
            parity_en_lat  <= parity_enable;
            parity_bit_lat <= (^tx_data) ^ parity_type;
            stop_two_lat   <= stop_bits;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
//
// Directed, self-checking bench for uart_tx_cfg. An 8-bit instance covers the
// main frame formats, back-to-back operation, shadowing of inputs and
// asynchronous abort. A 7-bit instance covers the zero-prescale corner.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] prescale;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        parity_enable;
    logic        parity_type;
    logic        stop_bits;
    logic        tx_ready;
    logic        tx_out;
    logic        busy;

    logic [15:0] prescale_7;
    logic [6:0]  tx_data_7;
    logic        tx_valid_7;
    logic        parity_enable_7;
    logic        parity_type_7;
    logic        stop_bits_7;
    logic        tx_ready_7;
    logic        tx_out_7;
    logic        busy_7;

    int compared   = 0;
    int mismatched = 0;

    logic cap_tx   [0:127];
    logic cap_busy [0:127];
    logic cap_rdy  [0:127];

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .prescale      (prescale),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .stop_bits     (stop_bits),
        .TX_OUT        (tx_out),
        .busy          (busy)
    );

    uart_tx_cfg #(.DATA_WIDTH(7), .PRESCALE_WIDTH(16)) dut7 (
        .clk           (clk),
        .rst           (rst),
        .prescale      (prescale_7),
        .tx_data       (tx_data_7),
        .tx_valid      (tx_valid_7),
        .tx_ready      (tx_ready_7),
        .parity_enable (parity_enable_7),
        .parity_type   (parity_type_7),
        .stop_bits     (stop_bits_7),
        .TX_OUT        (tx_out_7),
        .busy          (busy_7)
    );

    // Records n consecutive falling-edge samples of the 8-bit instance.
    task automatic capture(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[start+i]   = tx_out;
            cap_busy[start+i] = busy;
            cap_rdy[start+i]  = tx_ready;
        end
    endtask

    // Presents one payload and returns 1 ns into the first cycle after accept.
    task automatic send(input logic [7:0] d, input logic [15:0] p,
                        input logic pe, input logic pt, input logic sb);
        int waited;
        @(posedge clk); #1;
        tx_data       = d;
        prescale      = p;
        parity_enable = pe;
        parity_type   = pt;
        stop_bits     = sb;
        tx_valid      = 1'b1;
        waited        = 0;
        while (!tx_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!tx_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL send_timeout: tx_ready=%b required 1", tx_ready);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({tx_out, busy, tx_ready} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL reset_dut8: {tx,busy,ready}=%b required 100", {tx_out, busy, tx_ready});
        end
        compared++;
        if ({tx_out_7, busy_7, tx_ready_7} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL reset_dut7: {tx,busy,ready}=%b required 100", {tx_out_7, busy_7, tx_ready_7});
        end
        #2 rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({tx_out, busy, tx_ready} !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL post_reset_dut8: {tx,busy,ready}=%b required 101", {tx_out, busy, tx_ready});
        end
        compared++;
        if ({tx_out_7, busy_7, tx_ready_7} !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL post_reset_dut7: {tx,busy,ready}=%b required 101", {tx_out_7, busy_7, tx_ready_7});
        end
    endtask

    // 0xA5, 8N1, 4 cycles per bit; seq[k] is the k-th bit on the line.
    task automatic test_8n1();
        logic [9:0] seq;
        seq = 10'b1101001010;
        send(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0);
        capture(0, 41);
        for (int i = 0; i < 40; i++) begin
            compared++;
            if ({cap_tx[i], cap_busy[i], cap_rdy[i]} !== {seq[i/4], 2'b10}) begin
                mismatched++;
                $display("[TB] FAIL a5_8n1[%0d]: {tx,busy,ready}=%b required %b",
                         i, {cap_tx[i], cap_busy[i], cap_rdy[i]}, {seq[i/4], 2'b10});
            end
        end
        compared++;
        if ({cap_tx[40], cap_busy[40], cap_rdy[40]} !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL a5_8n1_idle: {tx,busy,ready}=%b required 101",
                     {cap_tx[40], cap_busy[40], cap_rdy[40]});
        end
    endtask

    // 0x03 with parity and two stop bits, 2 cycles per bit, 12-bit frame.
    task automatic test_parity(input logic odd);
        logic [11:0] seq;
        seq = odd ? 12'b111000000110 : 12'b110000000110;
        send(8'h03, 16'd2, 1'b1, odd, 1'b1);
        capture(0, 25);
        for (int i = 0; i < 24; i++) begin
            compared++;
            if ({cap_tx[i], cap_busy[i]} !== {seq[i/2], 1'b1}) begin
                mismatched++;
                $display("[TB] FAIL parity_odd%0d[%0d]: {tx,busy}=%b required %b",
                         odd, i, {cap_tx[i], cap_busy[i]}, {seq[i/2], 1'b1});
            end
        end
        compared++;
        if ({cap_tx[24], cap_busy[24]} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL parity_odd%0d_idle: {tx,busy}=%b required 10",
                     odd, {cap_tx[24], cap_busy[24]});
        end
    endtask

    // 0x55 then 0xF0 with tx_valid held high, 3 cycles per bit, 8N1.
    task automatic test_back_to_back();
        logic [7:0] rx1;
        logic [7:0] rx2;
        @(posedge clk); #1;
        tx_data       = 8'h55;
        prescale      = 16'd3;
        parity_enable = 1'b0;
        parity_type   = 1'b0;
        stop_bits     = 1'b0;
        tx_valid      = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'hF0;
        capture(0, 31);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        capture(31, 31);
        for (int j = 0; j < 8; j++) begin
            rx1[j] = cap_tx[(1+j)*3 + 1];
            rx2[j] = cap_tx[31 + (1+j)*3 + 1];
        end
        compared++;
        if (rx1 !== 8'h55) begin
            mismatched++;
            $display("[TB] FAIL b2b_payload1: got %h required 55", rx1);
        end
        compared++;
        if (rx2 !== 8'hF0) begin
            mismatched++;
            $display("[TB] FAIL b2b_payload2: got %h required f0", rx2);
        end
        compared++;
        if ({cap_tx[0], cap_tx[2], cap_tx[29], cap_busy[29]} !== 4'b0011) begin
            mismatched++;
            $display("[TB] FAIL b2b_frame1_edges: {start0,start2,stop,busy}=%b required 0011",
                     {cap_tx[0], cap_tx[2], cap_tx[29], cap_busy[29]});
        end
        compared++;
        if ({cap_tx[30], cap_busy[30], cap_rdy[30]} !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL b2b_gap: {tx,busy,ready}=%b required 101",
                     {cap_tx[30], cap_busy[30], cap_rdy[30]});
        end
        compared++;
        if ({cap_tx[31], cap_busy[31], cap_rdy[31]} !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL b2b_start2: {tx,busy,ready}=%b required 010",
                     {cap_tx[31], cap_busy[31], cap_rdy[31]});
        end
        compared++;
        if ({cap_tx[60], cap_busy[60], cap_tx[61], cap_busy[61]} !== 4'b1110) begin
            mismatched++;
            $display("[TB] FAIL b2b_frame2_end: {tx,busy,tx_next,busy_next}=%b required 1110",
                     {cap_tx[60], cap_busy[60], cap_tx[61], cap_busy[61]});
        end
    endtask

    // 0x81 with odd parity at 5 cycles/bit; every input changes during DATA.
    task automatic test_input_change();
        logic [10:0] seq;
        seq = 11'b11100000010;
        send(8'h81, 16'd5, 1'b1, 1'b1, 1'b0);
        capture(0, 10);
        tx_data       = 8'h00;
        prescale      = 16'd2;
        parity_enable = 1'b0;
        parity_type   = 1'b0;
        stop_bits     = 1'b1;
        capture(10, 46);
        for (int i = 0; i < 55; i++) begin
            compared++;
            if ({cap_tx[i], cap_busy[i]} !== {seq[i/5], 1'b1}) begin
                mismatched++;
                $display("[TB] FAIL shadow[%0d]: {tx,busy}=%b required %b",
                         i, {cap_tx[i], cap_busy[i]}, {seq[i/5], 1'b1});
            end
        end
        compared++;
        if ({cap_tx[55], cap_busy[55]} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL shadow_idle: {tx,busy}=%b required 10", {cap_tx[55], cap_busy[55]});
        end
    endtask

    // Abort 0xA5 during data bit 3, then send 0x3C at 2 cycles/bit.
    task automatic test_abort();
        logic [9:0] seq;
        seq = 10'b1001111000;
        send(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0);
        capture(0, 18);
        compared++;
        if ({cap_tx[17], cap_busy[17]} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL abort_pre: {tx,busy}=%b required 01", {cap_tx[17], cap_busy[17]});
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({tx_out, busy, tx_ready} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL abort_async: {tx,busy,ready}=%b required 100", {tx_out, busy, tx_ready});
        end
        @(negedge clk);
        compared++;
        if ({tx_out, busy, tx_ready} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL abort_hold: {tx,busy,ready}=%b required 100", {tx_out, busy, tx_ready});
        end
        #2 rst = 1'b0;
        send(8'h3C, 16'd2, 1'b0, 1'b0, 1'b0);
        capture(0, 21);
        for (int i = 0; i < 20; i++) begin
            compared++;
            if ({cap_tx[i], cap_busy[i]} !== {seq[i/2], 1'b1}) begin
                mismatched++;
                $display("[TB] FAIL after_abort[%0d]: {tx,busy}=%b required %b",
                         i, {cap_tx[i], cap_busy[i]}, {seq[i/2], 1'b1});
            end
        end
        compared++;
        if ({cap_tx[20], cap_busy[20]} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL after_abort_idle: {tx,busy}=%b required 10", {cap_tx[20], cap_busy[20]});
        end
    endtask

    // 7-bit instance, prescale 0 behaves as 1: 9-cycle frame for 0x7F.
    task automatic test_prescale_zero();
        logic exp_tx;
        logic exp_busy;
        @(posedge clk); #1;
        tx_data_7  = 7'h7F;
        prescale_7 = 16'd0;
        tx_valid_7 = 1'b1;
        compared++;
        if (tx_ready_7 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL p0_ready: tx_ready=%b required 1", tx_ready_7);
        end
        @(posedge clk); #1;
        tx_valid_7 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_tx   = (i == 0) ? 1'b0 : 1'b1;
            exp_busy = (i < 9) ? 1'b1 : 1'b0;
            compared++;
            if ({tx_out_7, busy_7} !== {exp_tx, exp_busy}) begin
                mismatched++;
                $display("[TB] FAIL p0_frame[%0d]: {tx,busy}=%b required %b",
                         i, {tx_out_7, busy_7}, {exp_tx, exp_busy});
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        prescale        = 16'd1;
        tx_data         = 8'h00;
        tx_valid        = 1'b0;
        parity_enable   = 1'b0;
        parity_type     = 1'b0;
        stop_bits       = 1'b0;
        prescale_7      = 16'd1;
        tx_data_7       = 7'h00;
        tx_valid_7      = 1'b0;
        parity_enable_7 = 1'b0;
        parity_type_7   = 1'b0;
        stop_bits_7     = 1'b0;

        test_reset();
        test_8n1();
        test_parity(1'b0);
        test_parity(1'b1);
        test_back_to_back();
        test_input_change();
        test_abort();
        test_prescale_zero();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
